// File: rtl/register_file_scoreboard.sv
// Two-read/one-write register file with an optional hardwired zero register,
// optional write-to-read bypass, and a per-register busy scoreboard for hazard detection.
module register_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] addressWrite,
    input  logic [DATA_WIDTH-1:0] dataWrite,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueAddress,
    input  logic [ADDR_WIDTH-1:0] addressA,
    input  logic [ADDR_WIDTH-1:0] addressB,
    output logic [DATA_WIDTH-1:0] dataA,
    output logic [DATA_WIDTH-1:0] dataB,
    output logic                  busyA,
    output logic                  busyB,
    output logic [ADDR_WIDTH:0]   pendingCount
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   pending_q;
    logic [ADDR_WIDTH:0]   pending_d;
    logic                  write_ok;
    logic                  issue_ok;

    // Anything aimed at the zero register is discarded before it can touch state.
    assign write_ok = writeEnable && !(ZERO_REG && addressWrite == '0);
    assign issue_ok = issueValid  && !(ZERO_REG && issueAddress == '0);

    always_comb begin
        busy_d    = busy_q;
        pending_d = '0;
        if (writeEnable) busy_d[addressWrite] = 1'b0;
        // A same-cycle issue wins: the new writer owns the register.
        if (issue_ok) busy_d[issueAddress] = 1'b1;
        if (ZERO_REG) busy_d[0] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_d = pending_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            if (write_ok) regs_q[addressWrite] <= dataWrite;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        dataA = regs_q[addressA];
        busyA = busy_q[addressA];
        if (BYPASS && write_ok && addressWrite == addressA) begin
            dataA = dataWrite;
            if (!(issue_ok && issueAddress == addressA)) busyA = 1'b0;
        end
        if (ZERO_REG && addressA == '0) begin
            dataA = '0;
            busyA = 1'b0;
        end
    end

    always_comb begin
        dataB = regs_q[addressB];
        busyB = busy_q[addressB];
        if (BYPASS && write_ok && addressWrite == addressB) begin
            dataB = dataWrite;
            if (!(issue_ok && issueAddress == addressB)) busyB = 1'b0;
        end
        if (ZERO_REG && addressB == '0) begin
            dataB = '0;
            busyB = 1'b0;
        end
    end

    assign pendingCount = pending_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: two instances (zero-reg+bypass, and neither)
// compared against an array-based reference model under directed and random stimulus.
module tb_register_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic [31:0] da [2];
    logic [31:0] db [2];
    logic        ba [2];
    logic        bb [2];
    logic [5:0]  pc [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = zero-reg+bypass, 1 = plain.
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];
    int          m_pend [2];

    always #5 clk = ~clk;

    register_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .writeEnable(we), .addressWrite(aw), .dataWrite(dw),
        .issueValid(iv), .issueAddress(ia), .addressA(aa), .addressB(ab),
        .dataA(da[0]), .dataB(db[0]), .busyA(ba[0]), .busyB(bb[0]), .pendingCount(pc[0])
    );

    register_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_plain (
        .clk(clk), .rst(rst), .writeEnable(we), .addressWrite(aw), .dataWrite(dw),
        .issueValid(iv), .issueAddress(ia), .addressA(aa), .addressB(ab),
        .dataA(da[1]), .dataB(db[1]), .busyA(ba[1]), .busyB(bb[1]), .pendingCount(pc[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit zr(input int c); return c == 0; endfunction
    function automatic bit byp(input int c); return c == 0; endfunction

    function automatic bit wr_kept(input int c);
        return we && !(zr(c) && aw == 5'd0);
    endfunction

    function automatic logic [31:0] exp_data(input int c, input logic [4:0] a);
        if (zr(c) && a == 5'd0) return 32'd0;
        if (byp(c) && wr_kept(c) && aw == a) return dw;
        return m_mem[c][a];
    endfunction

    function automatic logic exp_busy(input int c, input logic [4:0] a);
        bit iss_here;
        iss_here = iv && ia == a && !(zr(c) && a == 5'd0);
        if (zr(c) && a == 5'd0) return 1'b0;
        if (byp(c) && wr_kept(c) && aw == a && !iss_here) return 1'b0;
        return m_busy[c][a];
    endfunction

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[c][i]  = 32'd0;
                    m_busy[c][i] = 1'b0;
                end
            end else begin
                if (wr_kept(c)) m_mem[c][aw] = dw;
                if (we) m_busy[c][aw] = 1'b0;
                if (iv && !(zr(c) && ia == 5'd0)) m_busy[c][ia] = 1'b1;
            end
            m_pend[c] = 0;
            for (int i = 0; i < 32; i++) m_pend[c] += int'(m_busy[c][i]);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("dataA[%0d]", c), 64'(da[c]), 64'(exp_data(c, aa)));
            check($sformatf("dataB[%0d]", c), 64'(db[c]), 64'(exp_data(c, ab)));
            check($sformatf("busyA[%0d]", c), 64'(ba[c]), 64'(exp_busy(c, aa)));
            check($sformatf("busyB[%0d]", c), 64'(bb[c]), 64'(exp_busy(c, ab)));
            check($sformatf("pending[%0d]", c), 64'(pc[c]), 64'(m_pend[c]));
        end
    endtask

    task automatic half();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        half();
        tick();
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; iv = 1'b0; aw = '0; dw = '0; ia = '0;
    endtask

    initial begin
        idle();
        aa = '0; ab = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_update();
        #1;
        rst = 1'b0;

        // Every address reads zero and idle after reset.
        for (int a = 0; a < 32; a++) begin
            aa = 5'(a); ab = 5'(31 - a);
            cycle();
        end
        half();
        check("reset_pending", 64'(pc[0]), 64'd0);
        tick();

        // Bypass versus no bypass on r7.
        we = 1'b1; aw = 5'd7; dw = 32'hDEADBEEF; aa = 5'd7;
        half();
        check("bypass_same_cycle", 64'(da[0]), 64'hDEADBEEF);
        check("nobypass_old", 64'(da[1]), 64'd0);
        tick();
        idle();
        half();
        check("nobypass_next", 64'(da[1]), 64'hDEADBEEF);
        tick();

        // Zero register ignores write and issue.
        we = 1'b1; aw = 5'd0; dw = 32'h5; iv = 1'b1; ia = 5'd0; aa = 5'd0;
        cycle();
        idle();
        half();
        check("zero_data", 64'(da[0]), 64'd0);
        check("zero_busy", 64'(ba[0]), 64'd0);
        check("zero_pending", 64'(pc[0]), 64'd0);
        tick();

        // Issue r3,r4,r5, then retire r4.
        for (int k = 3; k <= 5; k++) begin
            iv = 1'b1; ia = 5'(k);
            cycle();
        end
        idle();
        half();
        check("three_pending", 64'(pc[0]), 64'd3);
        tick();
        we = 1'b1; aw = 5'd4; dw = 32'h44; aa = 5'd4;
        cycle();
        idle();
        half();
        check("r4_busy_clear", 64'(ba[0]), 64'd0);
        check("two_pending", 64'(pc[0]), 64'd2);
        tick();

        // Same-cycle issue and writeback of r9, first fresh then already busy.
        for (int rep = 0; rep < 2; rep++) begin
            iv = 1'b1; ia = 5'd9; we = 1'b1; aw = 5'd9; dw = 32'h12; aa = 5'd9;
            cycle();
            idle();
            half();
            check("r9_data", 64'(da[0]), 64'h12);
            check("r9_busy", 64'(ba[0]), 64'd1);
            check("r9_pending", 64'(pc[0]), 64'd3);
            tick();
        end

        // Reset mid-operation discards pending bits and beats the write.
        iv = 1'b1; ia = 5'd10; cycle();
        iv = 1'b1; ia = 5'd20; cycle();
        idle();
        rst = 1'b1; we = 1'b1; aw = 5'd10; dw = 32'hABCD;
        cycle();
        idle();
        aa = 5'd10; ab = 5'd20;
        half();
        check("rst_pending", 64'(pc[0]), 64'd0);
        check("rst_r10", 64'(da[0]), 64'd0);
        tick();
        we = 1'b1; aw = 5'd20; dw = 32'h7;
        cycle();
        idle();
        half();
        check("r20_data", 64'(db[0]), 64'h7);
        check("r20_busy", 64'(bb[0]), 64'd0);
        tick();

        // Random traffic; half the time addresses are squeezed to force collisions.
        for (int n = 0; n < 600; n++) begin
            automatic int hi = ($urandom_range(0, 1) == 1) ? 3 : 31;
            rst = ($urandom_range(0, 63) == 0);
            we  = $urandom_range(0, 1);
            iv  = $urandom_range(0, 1);
            aw  = 5'($urandom_range(0, hi));
            ia  = 5'($urandom_range(0, hi));
            aa  = 5'($urandom_range(0, hi));
            ab  = 5'($urandom_range(0, hi));
            dw  = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
